// File: rtl/seq_stage_controller.sv
// One-stage-per-cycle sequencer for the Y86-64 SEQ datapath: issues one-hot
// stage enables, tracks the architectural status and counts retired instructions.
module seq_stage_controller #(
    parameter int CNT_W     = 32,
    parameter int MAX_INSTR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             instr_invalid,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic             limit_hit,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_WRITEBACK = 4'd5,
        S_PCUPD     = 4'd6,
        S_PAUSE     = 4'd7,
        S_HALTED    = 4'd8
    } state_t;

    localparam logic [2:0]       STAT_AOK = 3'd1;
    localparam logic [2:0]       STAT_HLT = 3'd2;
    localparam logic [2:0]       STAT_ADR = 3'd3;
    localparam logic [2:0]       STAT_INS = 3'd4;
    localparam logic             LIMIT_ON = (MAX_INSTR != 0);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_INSTR);
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    logic [2:0]       next_stat_s;
    logic             next_limit_s;
    logic [CNT_W-1:0] next_retired_s;

    // Next-state, status and counter decisions for the current stage.
    always_comb begin
        next_state_s   = state_r;
        next_stat_s    = stat;
        next_limit_s   = limit_hit;
        next_retired_s = retired;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    next_stat_s  = STAT_ADR;
                    next_state_s = S_HALTED;
                end else if (instr_invalid) begin
                    next_stat_s  = STAT_INS;
                    next_state_s = S_HALTED;
                end else if (icode == 4'h0) begin
                    next_stat_s  = STAT_HLT;
                    next_state_s = S_HALTED;
                end else begin
                    next_state_s = S_DECODE;
                end
            end
            S_DECODE:  next_state_s = S_EXECUTE;
            S_EXECUTE: next_state_s = S_MEMORY;
            S_MEMORY: begin
                // A data fault stops before writeback so no state is committed.
                if (dmem_error) begin
                    next_stat_s  = STAT_ADR;
                    next_state_s = S_HALTED;
                end else begin
                    next_state_s = S_WRITEBACK;
                end
            end
            S_WRITEBACK: next_state_s = S_PCUPD;
            S_PCUPD: begin
                next_retired_s = retired + ONE;
                if (LIMIT_ON && (next_retired_s == LIMIT)) begin
                    next_limit_s = 1'b1;
                    next_state_s = S_HALTED;
                end else if (step_mode) begin
                    next_state_s = S_PAUSE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (step_req) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_PAUSE;
                end
            end
            S_HALTED: next_state_s = S_HALTED;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            mem_en    <= 1'b0;
            wb_en     <= 1'b0;
            pc_en     <= 1'b0;
            stat      <= STAT_AOK;
            busy      <= 1'b0;
            halted    <= 1'b0;
            limit_hit <= 1'b0;
            retired   <= {CNT_W{1'b0}};
        end else begin
            state_r   <= next_state_s;
            fetch_en  <= (next_state_s == S_FETCH);
            decode_en <= (next_state_s == S_DECODE);
            exec_en   <= (next_state_s == S_EXECUTE);
            mem_en    <= (next_state_s == S_MEMORY);
            wb_en     <= (next_state_s == S_WRITEBACK);
            pc_en     <= (next_state_s == S_PCUPD);
            stat      <= next_stat_s;
            busy      <= (next_state_s == S_FETCH)     || (next_state_s == S_DECODE) ||
                         (next_state_s == S_EXECUTE)   || (next_state_s == S_MEMORY) ||
                         (next_state_s == S_WRITEBACK) || (next_state_s == S_PCUPD);
            halted    <= (next_state_s == S_HALTED);
            limit_hit <= next_limit_s;
            retired   <= next_retired_s;
        end
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench: a program-level model queues the expected stage sequence,
// a monitor pops one entry per enabled cycle.
module tb_seq_stage_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, start = 1'b0, step_mode = 1'b0, step_req = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic        imem_error = 1'b0, instr_invalid = 1'b0, dmem_error = 1'b0;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic [2:0]  stat;
    logic        busy, halted, limit_hit;
    logic [31:0] retired;
    logic        l_fetch_en, l_decode_en, l_exec_en, l_mem_en, l_wb_en, l_pc_en;
    logic [2:0]  l_stat;
    logic        l_busy, l_halted, l_limit_hit;
    logic [31:0] l_retired;

    always #5 clk = ~clk;

    seq_stage_controller #(.CNT_W(32), .MAX_INSTR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step_req(step_req),
        .icode(icode), .imem_error(imem_error), .instr_invalid(instr_invalid), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en),
        .wb_en(wb_en), .pc_en(pc_en), .stat(stat), .busy(busy), .halted(halted),
        .limit_hit(limit_hit), .retired(retired));

    seq_stage_controller #(.CNT_W(32), .MAX_INSTR(2)) dut_lim (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step_req(step_req),
        .icode(icode), .imem_error(imem_error), .instr_invalid(instr_invalid), .dmem_error(dmem_error),
        .fetch_en(l_fetch_en), .decode_en(l_decode_en), .exec_en(l_exec_en), .mem_en(l_mem_en),
        .wb_en(l_wb_en), .pc_en(l_pc_en), .stat(l_stat), .busy(l_busy), .halted(l_halted),
        .limit_hit(l_limit_hit), .retired(l_retired));

    typedef struct { int stage; logic [31:0] ret; bit chk_gap; } exp_t;
    typedef struct { logic [3:0] op; bit imem; bit inv; bit dmem; } ins_t;

    exp_t        exp_q[$];
    ins_t        prog[$];
    int          pidx = 0;
    int          idle = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_stat;
    logic [31:0] exp_ret;
    bit          exp_lim;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int s, input logic [31:0] r, input bit g);
        exp_t e;
        e.stage = s; e.ret = r; e.chk_gap = g;
        return e;
    endfunction

    function automatic ins_t mk_ins(input logic [3:0] op, input bit im, input bit iv, input bit dm);
        ins_t x;
        x.op = op; x.imem = im; x.inv = iv; x.dmem = dm;
        return x;
    endfunction

    // Instruction-level model: which stages each instruction visits and how it ends.
    task automatic build_model(input bit step, input int limit);
        logic [31:0] r;
        r = 32'd0; exp_stat = 1; exp_lim = 1'b0;
        foreach (prog[i]) begin
            exp_q.push_back(mk(0, r, (i > 0) && !step));
            if (prog[i].imem) begin exp_stat = 3; break; end
            if (prog[i].inv)  begin exp_stat = 4; break; end
            if (prog[i].op == 4'h0) begin exp_stat = 2; break; end
            for (int s = 1; s <= 3; s++) exp_q.push_back(mk(s, r, 1'b1));
            if (prog[i].dmem) begin exp_stat = 3; break; end
            exp_q.push_back(mk(4, r, 1'b1));
            exp_q.push_back(mk(5, r, 1'b1));
            r = r + 32'd1;
            if (limit != 0 && r == limit) begin exp_lim = 1'b1; break; end
        end
        exp_ret = r;
    endtask

    // Program feeder: presents the next instruction while fetch is enabled.
    always @(negedge clk) begin
        if (fetch_en) begin
            if (pidx < prog.size()) begin
                icode = prog[pidx].op; imem_error = prog[pidx].imem;
                instr_invalid = prog[pidx].inv; dmem_error = prog[pidx].dmem;
                pidx++;
            end else begin
                icode = 4'h0; imem_error = 1'b0; instr_invalid = 1'b0; dmem_error = 1'b0;
            end
        end
    end

    // Monitor: every enabled cycle must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [5:0] en;
        exp_t e;
        en = {pc_en, wb_en, mem_en, exec_en, decode_en, fetch_en};
        if (en != 6'd0) begin
            check("onehot", $countones(en), 1);
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_enable: got %b, expected none (t=%0t)", en, $time);
            end else begin
                e = exp_q.pop_front();
                check("stage_enable", en, 1 << e.stage);
                check("retired_in_stage", retired, e.ret);
                check("stat_running", stat, 1);
                check("busy_running", busy, 1);
                if (e.chk_gap) check("no_gap", idle, 0);
            end
            idle = 0;
        end else begin
            idle++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step_req = 1'b0; step_mode = 1'b0;
        tick(); tick();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 600; i++) begin
            if (halted) break;
            tick();
        end
        check("halt_reached", halted, 1);
    endtask

    task automatic wait_pause();
        for (int i = 0; i < 50; i++) begin
            if (!busy && !halted) break;
            tick();
        end
        check("pause_reached", {busy, halted}, 0);
    endtask

    task automatic finish_checks();
        check("queue_drained", exp_q.size(), 0);
        check("final_stat", stat, exp_stat);
        check("final_retired", retired, exp_ret);
        check("final_busy", busy, 0);
        check("final_limit", limit_hit, 0);
        pulse_start();
        repeat (4) tick();
        check("sticky_halt", halted, 1);
        check("sticky_stat", stat, exp_stat);
    endtask

    task automatic run_prog();
        do_reset();
        build_model(1'b0, 0);
        pidx = 0;
        pulse_start();
        check("start_latency", fetch_en, 1);
        wait_halt();
        finish_checks();
    endtask

    function automatic logic [3:0] rnd_op();
        return 4'($urandom_range(1, 15));
    endfunction

    initial begin
        int en_cnt;
        do_reset();
        @(negedge clk);
        check("rst_stat", stat, 1);
        check("rst_flags", {busy, halted, limit_hit, fetch_en, pc_en}, 0);
        check("rst_retired", retired, 0);

        // Three normal instructions then a halt.
        prog = '{mk_ins(4'h6, 0, 0, 0), mk_ins(4'h6, 0, 0, 0), mk_ins(4'h6, 0, 0, 0), mk_ins(4'h0, 0, 0, 0)};
        run_prog();
        // Halt on the third fetch.
        prog = '{mk_ins(rnd_op(), 0, 0, 0), mk_ins(rnd_op(), 0, 0, 0), mk_ins(4'h0, 0, 0, 0)};
        run_prog();
        // ADR beats INS on the same fetch.
        prog = '{mk_ins(rnd_op(), 1, 1, 0)};
        run_prog();
        prog = '{mk_ins(4'h3, 0, 0, 0), mk_ins(rnd_op(), 0, 1, 0)};
        run_prog();
        // Data fault on the first instruction: no writeback, no retire.
        prog = '{mk_ins(4'h5, 0, 0, 1)};
        run_prog();

        // Retire limit, observed on the MAX_INSTR=2 instance.
        prog = '{mk_ins(rnd_op(), 0, 0, 0), mk_ins(rnd_op(), 0, 0, 0), mk_ins(rnd_op(), 0, 0, 0),
                 mk_ins(rnd_op(), 0, 0, 0), mk_ins(4'h0, 0, 0, 0)};
        run_prog();
        check("lim_limit_hit", l_limit_hit, 1);
        check("lim_stat", l_stat, 1);
        check("lim_retired", l_retired, 2);
        check("lim_halted", l_halted, 1);

        // Single-step mode.
        do_reset();
        prog = '{mk_ins(4'h6, 0, 0, 0), mk_ins(4'h9, 0, 0, 0), mk_ins(4'h0, 0, 0, 0)};
        build_model(1'b1, 0);
        pidx = 0;
        step_mode = 1'b1;
        pulse_start();
        check("step_start_latency", fetch_en, 1);
        wait_pause();
        check("pause_retired", retired, 1);
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            en_cnt += int'({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en} != 6'd0);
        end
        check("pause_idle", en_cnt, 0);
        step_req = 1'b1; tick(); step_req = 1'b0;
        check("step_latency", fetch_en, 1);
        wait_pause();
        check("pause2_retired", retired, 2);
        step_mode = 1'b0;
        repeat (3) tick();
        check("cleared_still_paused", {busy, halted}, 0);
        step_req = 1'b1; tick(); step_req = 1'b0;
        check("step2_latency", fetch_en, 1);
        wait_halt();
        finish_checks();

        // Reset mid-instruction, with start held during the reset edge.
        do_reset();
        prog = '{mk_ins(4'h6, 0, 0, 0), mk_ins(4'h6, 0, 0, 0), mk_ins(4'h0, 0, 0, 0)};
        build_model(1'b0, 0);
        pidx = 0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (exec_en) break;
            tick();
        end
        check("reached_execute", exec_en, 1);
        rst_n = 1'b0; start = 1'b1;
        tick();
        exp_q.delete();
        check("mid_rst_enables", {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en}, 0);
        check("mid_rst_stat", stat, 1);
        check("mid_rst_flags", {busy, halted, limit_hit}, 0);
        check("mid_rst_retired", retired, 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("rst_dominates_start", {fetch_en, busy}, 0);
        prog = '{mk_ins(4'h2, 0, 0, 0), mk_ins(4'h0, 0, 0, 0)};
        build_model(1'b0, 0);
        pidx = 0;
        pulse_start();
        check("restart_latency", fetch_en, 1);
        wait_halt();
        finish_checks();

        // Random programs with random faults, always ending in a halt.
        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, 5);
            prog.delete();
            for (int k = 0; k < len; k++) begin
                prog.push_back(mk_ins(4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
                                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0));
            end
            prog.push_back(mk_ins(4'h0, 0, 0, 0));
            run_prog();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle sequencer for the single-cycle Y86-64 SEQ datapath (fetch, decode, execute, memory, PC update). It replaces free-running clocking of every stage with a one-stage-per-cycle state machine. The machine issues a one-hot enable to each stage, samples the stage error flags at the stage that produces them, and maintains the architectural status code. It also supports run and single-step modes for bench and debug control, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter
- MAX_INSTR, 0, retire limit; 0 disables the limit

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- start  in  1  begin execution; honoured only in IDLE
- step_mode  in  1  1 = pause after every retired instruction
- step_req  in  1  advance one instruction; honoured only in PAUSE
- icode  in  4  instruction code from the fetch stage
- imem_error  in  1  instruction memory address error from fetch
- instr_invalid  in  1  fetch reports an illegal icode/ifun
- dmem_error  in  1  data memory address error from the memory stage
- fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out  1 each  stage enables; at most one asserted per cycle
- stat  out  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- busy  out  1  high in FETCH..PCUPD
- halted  out  1  high in HALTED
- limit_hit  out  1  high when execution stopped because the retire limit was reached
- retired  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, PAUSE, HALTED. Each stage state lasts exactly one cycle.
- Stage enables are decoded from the current state (Moore):
  - FETCH→fetch_en, DECODE→decode_en, EXECUTE→exec_en, MEMORY→mem_en, WRITEBACK→wb_en, PCUPD→pc_en.
  - All enables are 0 in IDLE, PAUSE and HALTED.
- IDLE: start=1 → FETCH; otherwise stay.
- FETCH exit checks, in priority order:
  - imem_error → stat=ADR, HALTED
  - else instr_invalid → stat=INS, HALTED
  - else icode==4'h0 → stat=HLT, HALTED
  - else → DECODE
- DECODE → EXECUTE → MEMORY, unconditionally.
- MEMORY: dmem_error → stat=ADR, HALTED. WRITEBACK and PCUPD are not entered, so register file and PC are unchanged.
- WRITEBACK → PCUPD, unconditionally.
- PCUPD: retired increments by 1. Next state, in priority order:
  - MAX_INSTR≠0 and new count==MAX_INSTR → HALTED with limit_hit=1, stat stays AOK
  - else step_mode=1 → PAUSE
  - else → FETCH
- PAUSE: step_req=1 → FETCH. If step_mode has been cleared, the controller still waits for one step_req before resuming.
- HALTED is sticky; only rst_n=0 leaves it.
- Ignored inputs:
  - start outside IDLE
  - step_req outside PAUSE
  - error flags in states other than the one that samples them
- retired wraps modulo 2^CNT_W. A halt instruction or a faulting instruction does not retire.

## Timing
- Reset (rst_n=0 at an edge) forces, on that edge:
  - state=IDLE
  - all enables 0
  - stat=AOK(1), busy=0, halted=0, limit_hit=0, retired=0
- Reset has the same effect from any state, including mid-instruction; no stage enable fires on the following cycle.
- Reset dominates start and step_req presented on the same edge.
- Latency:
  - start sampled at edge N → fetch_en high in cycle N+1.
  - A normal instruction occupies 6 consecutive cycles.
  - In run mode, the fetch_en of the next instruction follows pc_en with no gap.
- Counter update: retired reflects the increment in the cycle after PCUPD.
- Error timing:
  - stat and halted change on the edge that leaves the sampling state.
  - halted is high from the next cycle on.
- Error flags are sampled on the same edge as their stage enable cycle ends; inputs must be valid by then.
- Step timing: step_req sampled in PAUSE at edge N → fetch_en in cycle N+1.

## Test plan
- Reset then start pulse; icode=6 with no errors, run mode, 3 instructions → enables cycle fetch..pc_en, 18 cycles back-to-back; retired=3; stat=1.
- Program whose 3rd fetch presents icode=0 → HALTED after the FETCH cycle; stat=2; retired=2; no decode_en afterwards; start ignored.
- imem_error and instr_invalid both high in the same FETCH → stat=3 (ADR wins). Separately, instr_invalid alone → stat=4.
- dmem_error during mem_en of instruction 1 → stat=3; wb_en and pc_en never asserted; retired=0.
- step_mode=1 → PAUSE after each pc_en; step_req held 0 for 10 cycles → no enables; step_req pulse → fetch_en the next cycle. Also check MAX_INSTR=2 → limit_hit=1, stat=1, retired=2.
- rst_n low during EXECUTE → next cycle IDLE with all outputs at reset values. Then start → fetch_en one cycle later.
